// File: rtl/regfile_wb_scheduler.sv
// Write-back scheduler: arbitrates the register file's single write port between
// the ALU and LSU, and tracks pending writes for read-after-write hazard stalls.
module regfile_wb_scheduler #(
    parameter int unsigned MAX_WAIT = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    output logic        alu_ready,
    input  logic        lsu_valid,
    input  logic [4:0]  lsu_rd,
    input  logic [31:0] lsu_data,
    output logic        lsu_ready,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    input  logic        flush,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    output logic        rs1_busy,
    output logic        rs2_busy,
    output logic        rf_write_enable,
    output logic [4:0]  rf_rd,
    output logic [31:0] rf_write_data
);

    localparam int unsigned REG_W  = 5;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned NREG   = 32;
    localparam int unsigned CNT_W  = 3;

    logic [CNT_W-1:0]  wait_cnt;
    logic [CNT_W-1:0]  wait_cnt_nxt;
    logic [NREG-1:0]   busy;
    logic [NREG-1:0]   busy_nxt;
    logic              wait_full;
    logic              alu_grant;
    logic              lsu_grant;
    logic [REG_W-1:0]  wb_rd;
    logic [DATA_W-1:0] wb_data;

    assign wait_full = (wait_cnt == CNT_W'(MAX_WAIT));

    // LSU wins contention unless the ALU has waited MAX_WAIT cycles; no grants in reset.
    always_comb begin
        alu_grant = 1'b0;
        lsu_grant = 1'b0;
        if (reset) begin
            alu_grant = alu_valid & (~lsu_valid | wait_full);
            lsu_grant = lsu_valid & ~alu_grant;
        end
    end

    assign alu_ready = alu_grant;
    assign lsu_ready = lsu_grant;

    always_comb begin
        wb_rd   = lsu_rd;
        wb_data = lsu_data;
        if (alu_grant) begin
            wb_rd   = alu_rd;
            wb_data = alu_data;
        end
    end

    always_comb begin
        wait_cnt_nxt = wait_cnt;
        if (flush || !alu_valid || alu_grant) begin
            wait_cnt_nxt = '0;
        end else if (!wait_full) begin
            wait_cnt_nxt = wait_cnt + CNT_W'(1);
        end
    end

    // Clear from the write in flight, then set from issue so a newer writer stays pending.
    always_comb begin
        busy_nxt = busy;
        if (rf_write_enable) begin
            busy_nxt[rf_rd] = 1'b0;
        end
        if (flush) begin
            busy_nxt = '0;
        end else if (issue_valid && (issue_rd != REG_W'(0))) begin
            busy_nxt[issue_rd] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wait_cnt        <= '0;
            busy            <= '0;
            rf_write_enable <= 1'b0;
            rf_rd           <= '0;
            rf_write_data   <= '0;
        end else begin
            wait_cnt        <= wait_cnt_nxt;
            busy            <= busy_nxt;
            rf_write_enable <= (alu_grant | lsu_grant) & (wb_rd != REG_W'(0));
            if (alu_grant || lsu_grant) begin
                rf_rd         <= wb_rd;
                rf_write_data <= wb_data;
            end
        end
    end

    // The register being written this cycle is bypassed by the file, so it reads free.
    assign rs1_busy = busy[rs1] & ~(rf_write_enable & (rf_rd == rs1));
    assign rs2_busy = busy[rs2] & ~(rf_write_enable & (rf_rd == rs2));

endmodule

// File: doc/regfile_wb_scheduler.md
# regfile_wb_scheduler

Write-back scheduler for the 32×32 register file. It shares the file's single write port between two producers, the ALU and the load/store unit (LSU), using valid/ready arbitration with starvation protection. It also keeps a per-register pending-write scoreboard that the decode stage queries to stall on read-after-write hazards. It sits between the execute/memory stages and the register file's `rd`/`write_enable`/`write_data` inputs.

## Interface
- `MAX_WAIT`, default 3: number of consecutive denied cycles after which the ALU is forced to win; legal range 1–7; the wait counter is 3 bits.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  one clock; reset is synchronous and active-low (state clears on a rising `clk` edge while `reset`=0).
- `alu_valid`  in  1  ALU has a result to write back.
- `alu_rd`  in  5  ALU destination register.
- `alu_data`  in  32  ALU result, signed.
- `alu_ready`  out  1  ALU result accepted this cycle.
- `lsu_valid`, `lsu_rd`, `lsu_data`, `lsu_ready`: same meanings as the ALU signals, for the LSU.
- `issue_valid`  in  1  decode issues an instruction that writes `issue_rd`.
- `issue_rd`  in  5  destination register of the issued instruction.
- `flush`  in  1  pipeline flush; clears all scoreboard and wait state.
- `rs1`, `rs2`  in  5 each  scoreboard query addresses.
- `rs1_busy`, `rs2_busy`  out  1 each  the queried register has a pending write.
- `rf_write_enable`  out  1  register file write enable.
- `rf_rd`  out  5  register file destination.
- `rf_write_data`  out  32  register file write data, signed.

## Operation
- **Handshake.**
  - A transfer occurs on a rising edge when valid=1 and ready=1.
  - Ready is combinational from the valid inputs and the wait counter.
  - Valid must stay high with stable rd/data until the transfer occurs.
  - At most one ready is high per cycle.
- **Arbitration.**
  - Only one producer valid: that producer is granted.
  - Both valid: the LSU is granted, unless `wait_cnt == MAX_WAIT`, in which case the ALU is granted.
  - Neither valid: no grant; both readies are 0.
- **Wait counter** (3 bits):
  - Cleared when the ALU is granted, when `alu_valid`=0, or on `flush`.
  - Otherwise incremented when `alu_valid`=1 and `alu_ready`=0.
  - Saturates at `MAX_WAIT`.
- **Write port.**
  - The granted producer's rd/data are registered into `rf_rd`/`rf_write_data`.
  - `rf_write_enable` is set to 1 if rd≠0, else 0.
  - With no grant, `rf_write_enable` is 0 and `rf_rd`/`rf_write_data` hold their previous values.
  - A write to x0 completes the handshake but never asserts `rf_write_enable`.
- **Scoreboard.**
  - Holds busy[31:1]; busy[0] is hardwired 0.
  - Set: `issue_valid`=1 and `issue_rd`≠0 sets busy[issue_rd].
  - Clear: an edge with `rf_write_enable`=1 clears busy[rf_rd].
  - Set and clear of the same register on the same edge: set wins, because a newer writer is pending.
- **Query.**
  - `rsN_busy = busy[rsN] & ~(rf_write_enable & rf_rd == rsN)`.
  - The register being written this cycle reads as not busy, because the register file bypasses `write_data` during its write cycle.
  - rsN=0 always reads 0.
- **Flush.**
  - Clears all busy bits and the wait counter on the edge.
  - An issue in the same cycle is ignored.
  - A handshake in the same cycle still completes, and its write still reaches the register file.

## Timing
- **Reset values** (`reset`=0 at an edge):
  - `rf_write_enable`=0, `rf_rd`=0, `rf_write_data`=0.
  - busy=0, `wait_cnt`=0.
  - `alu_ready`=`lsu_ready`=0 while `reset`=0.
  - `rsN_busy`=0 after the reset edge.
- **Latency.**
  - Accept to register file write: 1 cycle. A transfer at edge N drives the `rf_*` signals during cycle N+1, and the register file writes at edge N+1.
  - Issue to busy visible on `rsN_busy`: the cycle after the issue edge.
  - Write to busy clear: `rsN_busy` drops combinationally in the cycle `rf_write_enable` is high. The busy bit itself clears at the following edge.
- **Throughput:** one write-back per cycle, sustained.
- **Reset mid-operation:**
  - Any transfer in the reset cycle is discarded.
  - No `rf_write_enable` pulse follows a reset edge.
- **Starvation bound:** with both producers continuously valid, the ALU is granted at least once every `MAX_WAIT`+1 cycles.

## Test plan
- **Reset:** hold `reset`=0 for 2 cycles with both valids high → both readies 0, `rf_write_enable`=0 and all busy bits 0; after release, the LSU is granted first.
- **Single write:** ALU valid, rd=5, data=0xFFFF_FFF6 → `alu_ready`=1; next cycle `rf_write_enable`=1, `rf_rd`=5, `rf_write_data`=0xFFFF_FFF6.
- **Contention, `MAX_WAIT`=3:** both producers valid continuously, ALU rd=1, LSU rd=2 → grant order is LSU, LSU, LSU, ALU, repeating.
- **Scoreboard:** issue rd=7 → `rs1`=7 reads busy the next cycle. LSU writes rd=7 → `rs1_busy`=0 in the `rf_write_enable` cycle and stays 0 afterwards. Issue rd=7 in the same cycle as the write → `rs1_busy` is 1 after that edge.
- **x0:** issue rd=0 and ALU write rd=0 → `alu_ready`=1, `rf_write_enable` stays 0, `rs1`=0 reads busy 0.
- **Flush:** busy bits 3 and 9 set, `flush` asserted together with an LSU write rd=3 and an issue of rd=4 → all busy bits 0 afterwards, the rd=3 write still appears on `rf_*`, and busy[4] stays 0.
